// File: rtl/uart_ascii_rx.sv
// uart_ascii_rx
//   8N1 UART receiver with an ASCII character classifier.
//   Each correctly framed byte is presented on rx_data with a one-cycle
//   rx_valid strobe. A byte whose stop bit samples low is dropped and
//   reported with a one-cycle frame_err strobe.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   r          UART RX line, asynchronous to clk, idle high
//   rx_valid   one-cycle pulse: rx_data/code hold a new byte
//   rx_data    last correctly received byte
//   frame_err  one-cycle pulse: stop bit low, byte discarded
//   code       combinational class of rx_data:
//                '0'..'7' -> 0..7, LF/CR -> 14, space -> 15, else 8
module uart_ascii_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic [3:0] code
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;
    logic          r_meta, rs;

    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            rs     <= 1'b1;
        end else begin
            r_meta <= r;
            rs     <= r_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        data_n    = rx_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (!rs) state_n = START;
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = rs ? IDLE : DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_n = '0;
                    shreg_n   = {rs, shreg[7:1]};  // LSB arrives first
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a start bit right after the stop
                // bit is caught without an idle gap.
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_n = '0;
                    state_n   = IDLE;
                    if (rs) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                    end else begin
                        ferr_n  = 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        code = 4'd8;
        if (rx_data >= 8'h30 && rx_data <= 8'h37)
            code = rx_data[3:0];
        else if (rx_data == 8'h0A || rx_data == 8'h0D)
            code = 4'd14;
        else if (rx_data == 8'h20)
            code = 4'd15;
    end

endmodule

// File: tb/tb_uart_ascii_rx.sv
// Self-checking bench for uart_ascii_rx with CLKS_PER_BIT = 16.
// Expected strobes are queued as frames are driven and compared when the
// DUT pulses rx_valid or frame_err.
module tb_uart_ascii_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_err;
    logic [3:0] code;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_strobe = 1'b0;

    uart_ascii_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r         (r),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .frame_err (frame_err),
        .code      (code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_code(input logic [7:0] b);
        if (b == 8'h20) return 4'd15;
        if (b == 8'h0A) return 4'd14;
        if (b == 8'h0D) return 4'd14;
        if (b[7:3] == 5'b00110) return {1'b0, b[2:0]};
        return 4'd8;
    endfunction

    // Scoreboard side: every strobe must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || frame_err)) begin
            chk("excl", {31'd0, rx_valid & frame_err}, 32'd0);
            chk("pulse", {31'd0, prev_strobe}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {31'd0, rx_valid}, {31'd0, frame_err});
                chk("unexpected_strobe", 32'd1, 32'd0 + exp_q.size());
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("kind_ferr", {31'd0, frame_err}, {31'd0, e.ferr});
                if (e.ferr) begin
                    chk("ferr_hold", {24'd0, rx_data}, {24'd0, last_good});
                end else begin
                    chk("data", {24'd0, rx_data}, {24'd0, e.data});
                    chk("code", {28'd0, code}, {28'd0, ref_code(e.data)});
                    last_good = e.data;
                end
            end
        end
        prev_strobe = rst_n && (rx_valid || frame_err);
    end

    task automatic send(input logic [7:0] b, input logic stop);
        exp_t e;
        e.ferr = ~stop;
        e.data = b;
        exp_q.push_back(e);
        r = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            r = b[i];
            repeat (CPB) @(negedge clk);
        end
        r = stop;
        repeat (CPB) @(negedge clk);
        r = 1'b1;
        if (!stop) repeat (2 * CPB) @(negedge clk);
    endtask

    // Drive a frame and pull reset in the middle of data bit abort_bit.
    task automatic send_abort(input logic [7:0] b, input int abort_bit);
        r = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < abort_bit; i++) begin
            r = b[i];
            repeat (CPB) @(negedge clk);
        end
        r = b[abort_bit];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, rx_valid}, 32'd0);
        chk("abort_ferr", {31'd0, frame_err}, 32'd0);
        chk("abort_data", {24'd0, rx_data}, 32'd0);
        chk("abort_code", {28'd0, code}, 32'd8);
        last_good = 8'h00;
        r = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        logic [7:0] good[8];
        r     = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_code", {28'd0, code}, 32'd8);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_code", {28'd0, code}, 32'd8);

        // Single byte, then back-to-back runs with no idle gap.
        good = '{8'h35, 8'h31, 8'h30, 8'h0A, 8'h41, 8'h39, 8'h20, 8'h00};
        foreach (good[i]) send(good[i], 1'b1);
        repeat (2) @(negedge clk);
        chk("last_data", {24'd0, rx_data}, 32'd0);
        send(8'h0D, 1'b1);

        // Bad stop bit, then a good byte.
        send(8'h33, 1'b0);
        send(8'h34, 1'b1);

        // Short glitch well under half a bit.
        r = 1'b0;
        repeat (5) @(negedge clk);
        r = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send(8'h31, 1'b1);
        repeat (CPB) @(negedge clk);

        send_abort(8'h37, 4);
        send(8'h32, 1'b1);

        for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
        chk("final_data", {24'd0, rx_data}, 32'h32);
        chk("final_code", {28'd0, code}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
